// File: rtl/branch_pc_unit_if.sv
// Signal bundle between the ID-stage control/comparator logic and the branch/PC unit.
// The slave modport is the PC unit's view; master is the driver side.
interface branch_pc_unit_if #(
    parameter int OFFSET_W = 8
);
    logic                stall;
    logic                branch_en;
    logic                comp_out;
    logic [OFFSET_W-1:0] branch_offset;
    logic [15:0]         id_pc;
    logic                jump_en;
    logic [15:0]         jump_target;
    logic                halt_req;
    logic [15:0]         pc;
    logic [15:0]         pc_plus2;
    logic                flush_ifid;
    logic                halted;
    logic [15:0]         taken_count;

    modport slave (
        input  stall, branch_en, comp_out, branch_offset, id_pc,
               jump_en, jump_target, halt_req,
        output pc, pc_plus2, flush_ifid, halted, taken_count
    );

    modport master (
        output stall, branch_en, comp_out, branch_offset, id_pc,
               jump_en, jump_target, halt_req,
        input  pc, pc_plus2, flush_ifid, halted, taken_count
    );
endinterface

// File: rtl/branch_pc_unit.sv
// Branch resolution and PC register: redirects on jumps and taken branches,
// issues a one-cycle IF/ID flush and counts redirects (saturating).
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_RUN   | normal fetch; evaluates halt / stall / jump / branch
// ST_FLUSH | one-cycle bubble after a redirect; ID requests ignored
// ST_HALT  | PC frozen, halted=1; left only through rst
module branch_pc_unit #(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter int          OFFSET_W = 8
) (
    input logic             clk,
    input logic             rst,
    branch_pc_unit_if.slave bus
);
    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_FLUSH = 2'd1,
        ST_HALT  = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] pc_q, pc_d;
    logic        flush_q, flush_d;
    logic        halted_q, halted_d;
    logic [15:0] taken_count_q;
    logic        redirect;

    logic [15:0] pc_inc;
    logic [15:0] offset_ext;
    logic [15:0] branch_target;
    logic [15:0] jump_addr;

    assign pc_inc        = pc_q + 16'd2;
    assign offset_ext    = 16'(signed'(bus.branch_offset));
    assign branch_target = bus.id_pc + (offset_ext << 1);
    assign jump_addr     = {bus.jump_target[15:1], 1'b0};

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        flush_d  = 1'b0;
        halted_d = halted_q;
        redirect = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (bus.halt_req && !bus.stall) begin
                    halted_d = 1'b1;
                    state_d  = ST_HALT;
                end else if (bus.stall) begin
                    pc_d = pc_q;
                end else if (bus.jump_en) begin
                    pc_d     = jump_addr;
                    flush_d  = 1'b1;
                    redirect = 1'b1;
                    state_d  = ST_FLUSH;
                end else if (bus.branch_en && bus.comp_out) begin
                    // branch_en gates comp_out so an undriven comparator never reaches pc
                    pc_d     = branch_target;
                    flush_d  = 1'b1;
                    redirect = 1'b1;
                    state_d  = ST_FLUSH;
                end else begin
                    pc_d = pc_inc;
                end
            end
            ST_FLUSH: begin
                if (!bus.stall) pc_d = pc_inc;
                state_d = ST_RUN;
            end
            ST_HALT: begin
                halted_d = 1'b1;
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_RUN;
            pc_q          <= RESET_PC;
            flush_q       <= 1'b0;
            halted_q      <= 1'b0;
            taken_count_q <= 16'h0000;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            flush_q  <= flush_d;
            halted_q <= halted_d;
            if (redirect && (taken_count_q != 16'hFFFF))
                taken_count_q <= taken_count_q + 16'd1;
        end
    end

    assign bus.pc          = pc_q;
    assign bus.pc_plus2    = pc_inc;
    assign bus.flush_ifid  = flush_q;
    assign bus.halted      = halted_q;
    assign bus.taken_count = taken_count_q;
endmodule

// File: tb/tb_branch_pc_unit.sv
// Directed bench for branch_pc_unit with hand-computed expected PC / flush / count values.
module tb_branch_pc_unit;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;

    branch_pc_unit_if #(.OFFSET_W(8)) bus ();

    branch_pc_unit #(.RESET_PC(16'h0000), .OFFSET_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_state(input string tag, input logic [15:0] exp_pc, input logic exp_flush,
                             input logic exp_halted, input logic [15:0] exp_cnt);
        chk({tag, ".pc"}, bus.pc, exp_pc);
        chk({tag, ".flush"}, {15'd0, bus.flush_ifid}, {15'd0, exp_flush});
        chk({tag, ".halted"}, {15'd0, bus.halted}, {15'd0, exp_halted});
        chk({tag, ".count"}, bus.taken_count, exp_cnt);
    endtask

    task automatic idle_inputs();
        bus.stall         = 1'b0;
        bus.branch_en     = 1'b0;
        bus.comp_out      = 1'b0;
        bus.branch_offset = 8'h00;
        bus.id_pc         = 16'h0000;
        bus.jump_en       = 1'b0;
        bus.jump_target   = 16'h0000;
        bus.halt_req      = 1'b0;
    endtask

    initial begin
        idle_inputs();
        tick();
        tick();
        rst = 1'b0;
        chk_state("reset", 16'h0000, 1'b0, 1'b0, 16'h0000);
        chk("pc_plus2", bus.pc_plus2, 16'h0002);

        for (int i = 1; i <= 4; i++) begin
            tick();
            chk_state("seq", 16'(2 * i), 1'b0, 1'b0, 16'h0000);
        end

        for (int i = 0; i < 4; i++) tick();
        chk("pc_0010", bus.pc, 16'h0010);

        // taken branch backwards: 000E + (-4 << 1) = 0006
        bus.branch_en = 1'b1; bus.comp_out = 1'b1;
        bus.id_pc = 16'h000E; bus.branch_offset = 8'hFC;
        tick();
        chk_state("br_taken", 16'h0006, 1'b1, 1'b0, 16'h0001);
        bus.branch_en = 1'b0; bus.comp_out = 1'b0;
        tick();
        chk_state("br_after", 16'h0008, 1'b0, 1'b0, 16'h0001);

        for (int i = 0; i < 12; i++) tick();
        chk("pc_0020", bus.pc, 16'h0020);
        bus.branch_en = 1'b1; bus.comp_out = 1'b0; bus.branch_offset = 8'h10;
        tick();
        chk_state("br_not_taken", 16'h0022, 1'b0, 1'b0, 16'h0001);
        bus.branch_en = 1'b0;

        bus.stall = 1'b1; bus.jump_en = 1'b1; bus.jump_target = 16'h1235;
        tick();
        chk_state("stall_jump", 16'h0022, 1'b0, 1'b0, 16'h0001);
        bus.stall = 1'b0;
        tick();
        chk_state("jump", 16'h1234, 1'b1, 1'b0, 16'h0002);
        bus.jump_en = 1'b0;
        tick();
        chk_state("jump_after", 16'h1236, 1'b0, 1'b0, 16'h0002);

        // jump and taken branch together; branch target would be 0180 + 0x40*2 = 0200
        bus.jump_en = 1'b1; bus.jump_target = 16'h0100;
        bus.branch_en = 1'b1; bus.comp_out = 1'b1;
        bus.id_pc = 16'h0180; bus.branch_offset = 8'h40;
        tick();
        chk_state("jump_wins", 16'h0100, 1'b1, 1'b0, 16'h0003);
        bus.jump_en = 1'b0;
        tick();
        chk_state("flush_ignores_br", 16'h0102, 1'b0, 1'b0, 16'h0003);
        bus.branch_en = 1'b0; bus.comp_out = 1'b0;

        bus.jump_en = 1'b1; bus.jump_target = 16'h2000;
        tick();
        chk_state("jump2", 16'h2000, 1'b1, 1'b0, 16'h0004);
        bus.jump_en = 1'b0; bus.stall = 1'b1;
        tick();
        chk_state("flush_stall", 16'h2000, 1'b0, 1'b0, 16'h0004);
        bus.stall = 1'b0;
        tick();
        chk_state("flush_stall_run", 16'h2002, 1'b0, 1'b0, 16'h0004);

        bus.jump_en = 1'b1; bus.jump_target = 16'hFFFC;
        tick();
        bus.jump_en = 1'b0;
        tick();
        chk_state("pc_fffe", 16'hFFFE, 1'b0, 1'b0, 16'h0005);
        chk("pc_plus2_wrap", bus.pc_plus2, 16'h0000);
        tick();
        chk_state("pc_wrap", 16'h0000, 1'b0, 1'b0, 16'h0005);

        // branch target wraps: FFF0 + 0x10*2 = 0010
        bus.branch_en = 1'b1; bus.comp_out = 1'b1;
        bus.id_pc = 16'hFFF0; bus.branch_offset = 8'h10;
        tick();
        chk_state("br_wrap", 16'h0010, 1'b1, 1'b0, 16'h0006);
        bus.branch_en = 1'b0; bus.comp_out = 1'b0;
        tick();
        chk_state("br_wrap_after", 16'h0012, 1'b0, 1'b0, 16'h0006);

        bus.stall = 1'b1; bus.halt_req = 1'b1;
        tick();
        chk_state("halt_stalled", 16'h0012, 1'b0, 1'b0, 16'h0006);
        bus.stall = 1'b0;
        tick();
        chk_state("halt", 16'h0012, 1'b0, 1'b1, 16'h0006);
        bus.halt_req = 1'b0;
        bus.jump_en = 1'b1; bus.jump_target = 16'h4444;
        bus.branch_en = 1'b1; bus.comp_out = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk_state("halt_hold", 16'h0012, 1'b0, 1'b1, 16'h0006);
        end

        rst = 1'b1;
        tick();
        chk_state("rst_halt", 16'h0000, 1'b0, 1'b0, 16'h0000);
        rst = 1'b0;
        idle_inputs();
        tick();
        chk_state("rst_halt_run", 16'h0002, 1'b0, 1'b0, 16'h0000);

        bus.jump_en = 1'b1; bus.jump_target = 16'h0800;
        tick();
        chk_state("jump3", 16'h0800, 1'b1, 1'b0, 16'h0001);
        bus.jump_en = 1'b0; rst = 1'b1;
        tick();
        chk_state("rst_flush", 16'h0000, 1'b0, 1'b0, 16'h0000);
        rst = 1'b0;
        tick();
        chk_state("rst_flush_run", 16'h0002, 1'b0, 1'b0, 16'h0000);

        // preload the counter just below saturation
        force dut.taken_count_q = 16'hFFFE;
        #1;
        release dut.taken_count_q;
        chk("count_preload", bus.taken_count, 16'hFFFE);
        bus.jump_en = 1'b1; bus.jump_target = 16'h0300;
        tick();
        chk_state("sat1", 16'h0300, 1'b1, 1'b0, 16'hFFFF);
        bus.jump_en = 1'b0;
        tick();
        bus.jump_en = 1'b1; bus.jump_target = 16'h0400;
        tick();
        chk_state("sat2", 16'h0400, 1'b1, 1'b0, 16'hFFFF);
        bus.jump_en = 1'b0;
        tick();
        chk_state("sat_after", 16'h0402, 1'b0, 1'b0, 16'hFFFF);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/branch_pc_unit.md
Name: branch_pc_unit

Overview:
- Branch-resolution and program-counter stage for the 16-bit pipelined CPU.
- Sits directly downstream of the branch comparator in ID. Consumes its taken/not-taken result (comp_out) together with jump requests from the control unit.
- Owns the PC register and produces the fetch address.
- On redirects, generates a one-cycle IF/ID flush and keeps a saturating taken-branch counter for debug.

Parameters:
- RESET_PC, 16'h0000, PC value loaded on reset.
- OFFSET_W, 8, width of the signed branch offset field from the instruction.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- stall  input  1  hazard-unit stall; holds PC; suppresses redirect evaluation.
- branch_en  input  1  ID holds a conditional branch (BLT/BGT/BEQ).
- comp_out  input  1  comparator result; meaningful only when branch_en=1.
- branch_offset  input  OFFSET_W  signed word offset from the branch instruction.
- id_pc  input  16  PC of the instruction currently in ID.
- jump_en  input  1  ID holds an unconditional jump.
- jump_target  input  16  absolute jump address.
- halt_req  input  1  ID holds a HALT instruction.
- pc  output  16  current fetch address, registered.
- pc_plus2  output  16  pc+2, combinational from pc.
- flush_ifid  output  1  registered; clears the IF/ID register for one cycle.
- halted  output  1  registered; high in HALT state.
- taken_count  output  16  count of taken branches plus jumps, saturating.

Behaviour:
- Reset (rst=1 at edge, overrides everything):
  - pc=RESET_PC, flush_ifid=0, halted=0, taken_count=0, state=RUN.
- States: RUN, FLUSH, HALT.
- Branch target: id_pc + (sign_extend(branch_offset) << 1), computed modulo 2^16.
- Jump target: jump_target with bit0 forced to 0.
- PC wrap: 16'hFFFE + 2 = 16'h0000. The same modulo rule applies to branch target addition.
- RUN, priority highest first:
  1. halt_req=1 and stall=0 -> pc holds, halted=1 next cycle, go HALT.
  2. stall=1 -> pc holds. branch_en, jump_en and halt_req are ignored this cycle. flush_ifid=0.
  3. jump_en=1 -> pc=jump target, flush_ifid=1, taken_count+1, go FLUSH.
  4. branch_en=1 and comp_out=1 -> pc=branch target, flush_ifid=1, taken_count+1, go FLUSH.
  5. Otherwise -> pc=pc+2.
  - jump_en and branch_en both high: the jump wins; the branch is ignored.
- FLUSH (exactly one cycle):
  - flush_ifid=1 during this cycle.
  - ID content is a squashed bubble, so branch_en, jump_en and halt_req are ignored.
  - pc=pc+2 if stall=0, else pc holds.
  - Next state is RUN; flush_ifid deasserts at the next edge.
  - If stall=1 in FLUSH, still go to RUN. The flush pulse is never extended.
- HALT:
  - pc frozen, halted=1. All inputs except rst are ignored.
  - Exit only via rst.
- taken_count: +1 per redirect, saturates at 16'hFFFF (no wrap).
- Latency: redirect decision in cycle N -> pc shows target in cycle N+1, and flush_ifid=1 in cycle N+1. Branch penalty is one bubble.
- Reset mid-FLUSH or mid-HALT: next cycle is RUN with pc=RESET_PC and flush_ifid=0.
- comp_out is never sampled when branch_en=0. X on comp_out must not propagate to pc.

Test Plan:
- Reset then 4 free-running cycles, no requests -> pc sequence 0000,0002,0004,0006,0008. flush_ifid=0, taken_count=0.
- pc=0010, branch_en=1, comp_out=1, id_pc=000E, offset=8'hFC (-4) -> next pc=0006, flush_ifid=1 for one cycle, then pc=0008. taken_count=1.
- branch_en=1, comp_out=0, pc=0020 -> pc=0022, no flush, taken_count unchanged.
- stall=1 with jump_en=1, jump_target=0x1235 -> pc holds for the stall cycle. When stall drops with jump_en still 1 -> pc=0x1234, flush pulse.
- Simultaneous jump_en=1 (target 0x0100) and taken branch (target 0x0200) -> pc=0x0100. A branch_en/comp_out pair asserted during the FLUSH cycle is ignored.
- pc=FFFE sequential -> pc=0000. Then halt_req=1 -> halted=1 and pc frozen for 10 cycles despite jump_en=1. Then rst=1 -> pc=RESET_PC, halted=0.
- Preload taken_count to FFFE via 65534 redirects (or force), then two more redirects -> taken_count stays FFFF.
